// File: rtl/uart_tx_engine.sv
// ---------------------------------------------------------------------------
// uart_tx_engine
//
// Transmit half of a 16550-style UART: a 16 x 8 FIFO feeding a serializer
// that emits start, 5..8 data bits (LSB first), optional parity and 1/2 stop
// bits. Every bit lasts 16 pulses of the 16x baud tick "enable".
//
// Ports
//   clk        in   system clock, rising edge
//   wb_rst_i   in   asynchronous active-high reset
//   lcr[7:0]   in   line control: [1:0] word length-5, [2] stop select,
//                   [3] parity enable, [4] even parity, [5] stick parity,
//                   [6] break
//   tf_push    in   one-cycle write strobe into the FIFO
//   wb_dat_i   in   byte written on tf_push
//   enable     in   16x baud tick (one-cycle pulse)
//   tx_reset   in   one-cycle synchronous flush of FIFO and serializer
//   stx_pad_o  out  serial line, idle high (registered)
//   state      out  FSM state (registered): 0 IDLE, 1 POP, 2 START, 3 DATA,
//                   4 PARITY, 5 STOP
//   tf_count   out  FIFO occupancy 0..16 (registered)
//   tf_full    out  high when tf_count = 16 (registered)
//
// Flow control: tf_push has no back-pressure. A push that arrives while the
// FIFO holds 16 bytes is silently dropped; tf_full is the only indication
// the writer gets.
//
// Build option: define UART_TX_HALF_STOP_EN to make the two-stop-bit setting
// produce 1.5 stop bits (24 ticks) when the word length is 5 bits.
// ---------------------------------------------------------------------------
module uart_tx_engine (
  input  logic       clk,
  input  logic       wb_rst_i,
  input  logic [7:0] lcr,
  input  logic       tf_push,
  input  logic [7:0] wb_dat_i,
  input  logic       enable,
  input  logic       tx_reset,
  output logic       stx_pad_o,
  output logic [2:0] state,
  output logic [4:0] tf_count,
  output logic       tf_full
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP    = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } tx_state_e;

  // FIFO storage and bookkeeping
  logic [7:0] fifo_q [16];
  logic [3:0] wr_ptr_q, wr_ptr_d;
  logic [3:0] rd_ptr_q, rd_ptr_d;
  logic [4:0] count_q, count_d;
  logic       full_q, full_d;
  logic       do_push, do_pop;

  // Serializer
  tx_state_e  state_q, state_d;
  logic [4:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shr_q, shr_d;
  logic [3:0] lcr_q, lcr_d;     // word length, stop select, parity enable
  logic       par_q, par_d;
  logic       stx_q, stx_d;

  logic [4:0] tick_last;
  logic [4:0] stop_last;
  logic [2:0] last_bit;
  logic       bit_end;
  logic [7:0] fifo_head;
  logic [7:0] word_mask;
  logic       data_xor;
  logic       par_calc;
  logic       line_lvl;
  logic       lcr_unused;

  assign lcr_unused = lcr[7];

  // -------------------------------------------------------------------------
  // FIFO
  // -------------------------------------------------------------------------
  // The pop is tied to the single POP cycle of the FSM. A full FIFO never
  // accepts a push, even when a pop happens in the same cycle.
  assign do_push = tf_push && !full_q && !tx_reset;
  assign do_pop  = (state_q == S_POP) && !tx_reset;

  assign fifo_head = fifo_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (tx_reset) begin
      wr_ptr_d = 4'd0;
      rd_ptr_d = 4'd0;
      count_d  = 5'd0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 4'd1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 4'd1;
      count_d = count_q + {4'd0, do_push} - {4'd0, do_pop};
    end
    full_d = (count_d == 5'd16);
  end

  // Storage has no reset: contents are only ever read behind a valid count.
  always_ff @(posedge clk) begin
    if (do_push) fifo_q[wr_ptr_q] <= wb_dat_i;
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= 4'd0;
      rd_ptr_q <= 4'd0;
      count_q  <= 5'd0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // -------------------------------------------------------------------------
  // Parity of the byte about to be loaded, using the live lcr that is being
  // sampled in POP. Bits above the word length are masked off.
  // -------------------------------------------------------------------------
  assign word_mask = 8'hFF >> (~lcr[1:0]);
  assign data_xor  = ^(fifo_head & word_mask);
  assign par_calc  = lcr[5] ? ~lcr[4] : (lcr[4] ? data_xor : ~data_xor);

  // -------------------------------------------------------------------------
  // Bit timing
  // -------------------------------------------------------------------------
`ifdef UART_TX_HALF_STOP_EN
  always_comb begin
    if (!lcr_q[2])                stop_last = 5'd15;
    else if (lcr_q[1:0] == 2'b00) stop_last = 5'd23;
    else                          stop_last = 5'd31;
  end
`else
  always_comb begin
    if (!lcr_q[2]) stop_last = 5'd15;
    else           stop_last = 5'd31;
  end
`endif

  assign tick_last = (state_q == S_STOP) ? stop_last : 5'd15;
  assign last_bit  = 3'd4 + {1'b0, lcr_q[1:0]};

  // -------------------------------------------------------------------------
  // FSM next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shr_d   = shr_q;
    lcr_d   = lcr_q;
    par_d   = par_q;
    bit_end = 1'b0;

    // Only the line-driving states count ticks; an idle clock holds the count.
    if ((state_q inside {S_START, S_DATA, S_PARITY, S_STOP}) && enable) begin
      if (tick_q == tick_last) begin
        bit_end = 1'b1;
        tick_d  = 5'd0;
      end else begin
        tick_d  = tick_q + 5'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        tick_d = 5'd0;
        if (count_q != 5'd0) state_d = S_POP;
      end
      S_POP: begin
        shr_d   = fifo_head;
        lcr_d   = lcr[3:0];
        par_d   = par_calc;
        bit_d   = 3'd0;
        tick_d  = 5'd0;
        state_d = S_START;
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == last_bit) begin
            state_d = lcr_q[3] ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            shr_d = {1'b0, shr_q[7:1]};
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        tick_d  = 5'd0;
      end
    endcase

    if (tx_reset) begin
      state_d = S_IDLE;
      tick_d  = 5'd0;
      bit_d   = 3'd0;
    end
  end

  // Line level is derived from the next state so the registered pin lines up
  // with the registered state output.
  always_comb begin
    line_lvl = 1'b1;
    case (state_d)
      S_START:  line_lvl = 1'b0;
      S_DATA:   line_lvl = shr_d[0];
      S_PARITY: line_lvl = par_d;
      default:  line_lvl = 1'b1;
    endcase
    if (tx_reset)    stx_d = 1'b1;
    else if (lcr[6]) stx_d = 1'b0;
    else             stx_d = line_lvl;
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      tick_q  <= 5'd0;
      bit_q   <= 3'd0;
      shr_q   <= 8'd0;
      lcr_q   <= 4'd0;
      par_q   <= 1'b0;
      stx_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shr_q   <= shr_d;
      lcr_q   <= lcr_d;
      par_q   <= par_d;
      stx_q   <= stx_d;
    end
  end

  assign stx_pad_o = stx_q;
  assign state     = state_q;
  assign tf_count  = count_q;
  assign tf_full   = full_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
module tb_uart_tx_engine;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       wb_rst_i;
  logic [7:0] lcr;
  logic       tf_push;
  logic [7:0] wb_dat_i;
  logic       enable;
  logic       tx_reset;
  logic       stx_pad_o;
  logic [2:0] state;
  logic [4:0] tf_count;
  logic       tf_full;

  always #5 clk = ~clk;

  uart_tx_engine dut (
    .clk       (clk),
    .wb_rst_i  (wb_rst_i),
    .lcr       (lcr),
    .tf_push   (tf_push),
    .wb_dat_i  (wb_dat_i),
    .enable    (enable),
    .tx_reset  (tx_reset),
    .stx_pad_o (stx_pad_o),
    .state     (state),
    .tf_count  (tf_count),
    .tf_full   (tf_full)
  );

`ifdef UART_TX_HALF_STOP_EN
  localparam int STOP5_TWO = 24;
`else
  localparam int STOP5_TWO = 32;
`endif

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: each accepted byte becomes {lcr, data} in exp_q; when
  // a frame starts on the line it is expanded into one expected level per
  // enable tick.
  // -------------------------------------------------------------------------
  logic [15:0] exp_q[$];
  logic        line_q[$];
  int          m_cnt = 0;
  bit          mon_on = 0;
  bit          in_frame = 0;
  bit          ack_pending = 0;
  logic        prev_stx = 1'b1;
  int          frames = 0;
  int          en_mode = 0;   // 0 off, 1 every cycle, 2 random

  task automatic build_frame(input logic [15:0] e);
    logic [7:0] d;
    logic [7:0] l;
    logic       x;
    logic       p;
    int         nb;
    int         stop_t;
    d = e[7:0];
    l = e[15:8];
    nb = 5 + int'(l[1:0]);
    x = 1'b0;
    line_q.delete();
    repeat (16) line_q.push_back(1'b0);
    for (int b = 0; b < nb; b++) begin
      x = x ^ d[b];
      repeat (16) line_q.push_back(d[b]);
    end
    if (l[3]) begin
      p = l[5] ? ~l[4] : (l[4] ? x : ~x);
      repeat (16) line_q.push_back(p);
    end
    stop_t = l[2] ? 32 : 16;
`ifdef UART_TX_HALF_STOP_EN
    if (l[2] && l[1:0] == 2'b00) stop_t = 24;
`endif
    repeat (stop_t) line_q.push_back(1'b1);
  endtask

  // Line monitor / scoreboard
  always @(negedge clk) begin
    logic lvl;
    if (mon_on) begin
      if (ack_pending) begin
        check_eq("idle_after_stop", 32'(state), 32'd0);
        ack_pending = 0;
      end
      if (!in_frame && prev_stx && !stx_pad_o) begin
        check_eq("start_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          build_frame(exp_q.pop_front());
          in_frame = 1;
          m_cnt--;
        end
      end
      if (in_frame && enable) begin
        lvl = line_q.pop_front();
        check_eq("line_bit", 32'(stx_pad_o), 32'(lvl));
        if (line_q.size() == 0) begin
          check_eq("last_tick_in_stop", 32'(state), 32'd5);
          in_frame = 0;
          ack_pending = 1;
          frames++;
        end
      end
    end
    prev_stx = stx_pad_o;
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  initial begin
    enable = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (en_mode)
        0:       enable = 1'b0;
        1:       enable = 1'b1;
        default: enable = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic push_byte(input logic [7:0] d);
    @(posedge clk); #1;
    tf_push  = 1'b1;
    wb_dat_i = d;
    if (m_cnt < 16) begin
      exp_q.push_back({lcr, d});
      m_cnt++;
    end
    @(posedge clk); #1;
    tf_push = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !in_frame && !ack_pending && state == 3'd0 && tf_count == 5'd0)
           && n < 20000) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq({tag, "_drain_in_time"}, 32'(n < 20000), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (state != s && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_reached"}, 32'(n < 2000), 32'd1);
  endtask

  task automatic monitor_restart();
    exp_q.delete();
    line_q.delete();
    m_cnt = 0;
    in_frame = 0;
    ack_pending = 0;
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int f0;
    int cnt;
    int n;
    bit saw_low;
    bit saw_start;
    bit saw_stop;
    bit left_idle;
    logic [7:0] par_lcr [3];
    logic       par_exp [3];

    wb_rst_i = 1'b1;
    lcr      = 8'h03;
    tf_push  = 1'b0;
    wb_dat_i = 8'h00;
    tx_reset = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_stx", 32'(stx_pad_o), 32'd1);
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_count", 32'(tf_count), 32'd0);
    check_eq("rst_full", 32'(tf_full), 32'd0);
    @(posedge clk); #1;
    wb_rst_i = 1'b0;

    // Basic 8N1 frame of 0x55
    mon_on  = 1;
    en_mode = 1;
    f0 = frames;
    push_byte(8'h55);
    @(negedge clk);
    check_eq("t55_idle_state", 32'(state), 32'd0);
    check_eq("t55_idle_count", 32'(tf_count), 32'd1);
    @(negedge clk);
    check_eq("t55_pop_state", 32'(state), 32'd1);
    check_eq("t55_pop_count", 32'(tf_count), 32'd1);
    @(negedge clk);
    check_eq("t55_start_state", 32'(state), 32'd2);
    check_eq("t55_start_count", 32'(tf_count), 32'd0);
    check_eq("t55_start_stx", 32'(stx_pad_o), 32'd0);
    wait_drain("t55");
    check_eq("t55_frames", 32'(frames - f0), 32'd1);

    // Parity variants on 0x07
    par_lcr[0] = 8'h1B; par_exp[0] = 1'b1;
    par_lcr[1] = 8'h0B; par_exp[1] = 1'b0;
    par_lcr[2] = 8'h3B; par_exp[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lcr = par_lcr[i];
      push_byte(8'h07);
      wait_state(3'd4, "par_state");
      check_eq("parity_bit", 32'(stx_pad_o), 32'(par_exp[i]));
      wait_drain("parity");
    end

    // Overflow: hold the serializer in START, then push 17 bytes
    lcr     = 8'h03;
    en_mode = 0;
    f0 = frames;
    push_byte(8'hA5);
    repeat (4) @(negedge clk);
    check_eq("ovf_held_in_start", 32'(state), 32'd2);
    for (int i = 0; i < 17; i++) push_byte(8'(i + 1));
    @(negedge clk);
    check_eq("ovf_count", 32'(tf_count), 32'd16);
    check_eq("ovf_full", 32'(tf_full), 32'd1);
    en_mode = 1;
    wait_drain("ovf");
    check_eq("ovf_frames", 32'(frames - f0), 32'd17);
    check_eq("ovf_full_after", 32'(tf_full), 32'd0);

    // 5-bit word, two-stop select
    lcr = 8'h04;
    push_byte(8'h1F);
    wait_state(3'd5, "stop5");
    cnt = 0;
    while (state == 3'd5 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check_eq("stop5_ticks", 32'(cnt), 32'(STOP5_TWO));
    wait_drain("stop5");

    // tx_reset in the middle of DATA with three bytes queued
    mon_on = 0;
    lcr = 8'h03;
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    wait_state(3'd3, "txr_data");
    repeat (20) @(negedge clk);
    check_eq("txr_queued", 32'(tf_count), 32'd3);
    @(posedge clk); #1;
    tx_reset = 1'b1;
    tf_push  = 1'b1;
    wb_dat_i = 8'hEE;
    @(posedge clk); #1;
    tx_reset = 1'b0;
    tf_push  = 1'b0;
    @(negedge clk);
    check_eq("txr_state", 32'(state), 32'd0);
    check_eq("txr_count", 32'(tf_count), 32'd0);
    check_eq("txr_stx", 32'(stx_pad_o), 32'd1);
    saw_low = 0;
    left_idle = 0;
    repeat (400) begin
      @(negedge clk);
      if (!stx_pad_o) saw_low = 1;
      if (state != 3'd0) left_idle = 1;
    end
    check_eq("txr_no_start", 32'(saw_low), 32'd0);
    check_eq("txr_stays_idle", 32'(left_idle), 32'd0);
    monitor_restart();

    // Asynchronous reset in the middle of a character
    push_byte(8'h3C);
    push_byte(8'hC3);
    wait_state(3'd3, "arst_data");
    repeat (7) @(negedge clk);
    #2;
    wb_rst_i = 1'b1;
    #1;
    check_eq("arst_stx", 32'(stx_pad_o), 32'd1);
    check_eq("arst_state", 32'(state), 32'd0);
    check_eq("arst_count", 32'(tf_count), 32'd0);
    check_eq("arst_full", 32'(tf_full), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    wb_rst_i = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("arst_after_state", 32'(state), 32'd0);
    check_eq("arst_after_stx", 32'(stx_pad_o), 32'd1);
    monitor_restart();

    // Break: line held low while a character still runs through the FSM
    lcr = 8'h43;
    repeat (3) @(negedge clk);
    check_eq("brk_idle_low", 32'(stx_pad_o), 32'd0);
    push_byte(8'h81);
    saw_low = 0;   // here: set if the line is ever high
    saw_start = 0;
    saw_stop = 0;
    n = 0;
    while (!(saw_stop && state == 3'd0) && n < 1000) begin
      @(negedge clk);
      if (stx_pad_o) saw_low = 1;
      if (state == 3'd2) saw_start = 1;
      if (state == 3'd5) saw_stop = 1;
      n++;
    end
    check_eq("brk_line_high_seen", 32'(saw_low), 32'd0);
    check_eq("brk_start_seen", 32'(saw_start), 32'd1);
    check_eq("brk_stop_seen", 32'(saw_stop), 32'd1);
    check_eq("brk_back_idle", 32'(state), 32'd0);
    lcr = 8'h03;
    repeat (2) @(negedge clk);
    check_eq("brk_release_stx", 32'(stx_pad_o), 32'd1);
    monitor_restart();
    prev_stx = 1'b1;
    mon_on = 1;

    // Randomized batches
    for (int b = 0; b < 4; b++) begin
      lcr = 8'($urandom_range(0, 63));
      en_mode = (b % 2 == 1) ? 2 : 1;
      f0 = frames;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        push_byte(8'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 5)) @(posedge clk);
      end
      wait_drain("rand");
      check_eq("rand_frames", 32'(frames - f0), 32'(n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-002 SHALL have port wb_rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port lcr, input, 8 bits: line control; [1:0] word length (00=5..11=8), [2] stop select, [3] parity enable, [4] even parity, [5] stick parity, [6] break.
REQ-004 SHALL have port tf_push, input, 1 bit: single-cycle write strobe into the transmit FIFO.
REQ-005 SHALL have port wb_dat_i, input, 8 bits: byte written when tf_push=1.
REQ-006 SHALL have port enable, input, 1 bit: 16x baud tick, one-cycle pulse.
REQ-007 SHALL have port tx_reset, input, 1 bit: synchronous FIFO/serializer flush, single-cycle.
REQ-008 SHALL have port stx_pad_o, output, 1 bit: serial line, idle high.
REQ-009 SHALL have port state, output, 3 bits: current FSM state encoding.
REQ-010 SHALL have port tf_count, output, 5 bits: FIFO occupancy 0..16.
REQ-011 SHALL have port tf_full, output, 1 bit: high when tf_count=16.

Function
REQ-012 SHALL buffer bytes in a 16-entry x 8-bit FIFO, first-in first-out.
REQ-013 SHALL write wb_dat_i on tf_push when not full and increment tf_count.
REQ-014 SHALL drop the byte on tf_push when full, leaving contents and tf_count=16 unchanged.
REQ-015 SHALL leave tf_count unchanged on simultaneous push and pop while not full; when full, the pop SHALL proceed and the push SHALL be dropped.
REQ-016 SHALL wrap read/write pointers modulo 16.
REQ-017 SHALL use FSM states IDLE=0, POP=1, START=2, DATA=3, PARITY=4, STOP=5.
REQ-018 SHALL go IDLE->POP on the cycle after tf_count>0 is seen in IDLE.
REQ-019 SHALL, in POP (one cycle), read the FIFO head into the shift register, decrement tf_count, and go to START.
REQ-020 SHALL time each bit as 16 enable pulses using a 5-bit tick counter cleared on every state entry; clk cycles without enable SHALL not advance the counter.
REQ-021 SHALL drive stx_pad_o=0 in START, then go to DATA.
REQ-022 SHALL, in DATA, send 5+lcr[1:0] bits LSB first, then go to PARITY if lcr[3]=1, else STOP.
REQ-023 SHALL set the PARITY bit to: stick (lcr[5]=1) = ~lcr[4]; even (lcr[4]=1) = XOR of the sent data bits; odd = inverse of that XOR.
REQ-024 SHALL, in STOP, drive 1 for 16 ticks if lcr[2]=0, 32 ticks if lcr[2]=1, then go to IDLE.
REQ-025 SHALL drive stx_pad_o=1 in IDLE and POP.
REQ-026 SHALL sample lcr in POP and hold the sampled value for the whole character.
REQ-027 SHALL force stx_pad_o=0 while lcr[6]=1, with the FSM and FIFO advancing as normal.
REQ-028 SHALL, on tx_reset, on the next edge clear the FIFO (tf_count=0, pointers 0), enter IDLE, and drive stx_pad_o=1, aborting any character in progress; a tf_push in the same cycle SHALL be discarded.
REQ-029 SHALL register stx_pad_o, state, tf_count and tf_full, with no combinational path from inputs.

Reset
REQ-030 SHALL, while wb_rst_i=1, set stx_pad_o=1, state=0 (IDLE), tf_count=0, tf_full=0, FIFO pointers 0, tick counter 0, bit counter 0.
REQ-031 SHALL abort any character in progress on reset assertion and SHALL start normal operation on the first clk edge after deassertion.

Configuration
REQ-032 SHALL use macro UART_TX_HALF_STOP_EN: when defined, with lcr[2]=1 and lcr[1:0]=00 (5-bit), STOP lasts 24 ticks (1.5 stop bits).
REQ-033 SHALL, when UART_TX_HALF_STOP_EN is undefined, make STOP 32 ticks for lcr[2]=1 at every word length.

Verification
REQ-034 SHALL test lcr=0x03, push 0x55, enable every cycle: stx = 0, 1,0,1,0,1,0,1,0, 1 (LSB first), each bit 16 cycles; state returns to 0; tf_count 1->0 in POP.
REQ-035 SHALL test lcr=0x1B (8 bits, even parity), push 0x07: parity bit=1; with lcr=0x0B (odd parity): parity bit=0; with lcr=0x3B (stick): parity bit=0.
REQ-036 SHALL test 17 pushes with no enable: tf_count=16, tf_full=1, 17th byte dropped; after draining, bytes 1..16 are sent in order.
REQ-037 SHALL test lcr=0x04 (5 bits, 2-stop select), push 0x1F: STOP lasts 24 ticks with UART_TX_HALF_STOP_EN defined and 32 ticks without it.
REQ-038 SHALL test tx_reset mid-DATA with 3 bytes queued: next cycle state=0, tf_count=0, stx_pad_o=1, and no further start bit.
REQ-039 SHALL test wb_rst_i asserted mid-character and lcr[6]=1 break: reset gives the REQ-030 values immediately; break holds stx_pad_o=0 while state still cycles.
